// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between requesters and the round-robin grant scheduler.
// The requester side drives req/done; the scheduler side drives the decoder controls.
interface rr_grant_scheduler_if;
    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [N_REQ-1:0] gnt;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  en,
        input  gnt,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output en,
        output gnt,
        output timeout
    );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Eight-way round-robin grant scheduler with bounded hold time and one idle cycle between grants.
// Drives a 3-to-8 decoder (sel/en) plus a bit-reversed one-hot grant vector; all outputs registered.
module rr_grant_scheduler #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic                  clk,
    input logic                  rst,
    rr_grant_scheduler_if.slave  bus
);

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_grant_scheduler: MAX_HOLD must lie in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                en_q, en_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic                timeout_q, timeout_d;

    logic [SEL_W-1:0]    winner;
    logic                win_found;
    logic [HOLD_W-1:0]   hold_now;
    logic                limit_hit;
    logic                req_held;
    logic                exit_grant;

    // Rotating priority search: first set request at or above ptr, wrapping 7 -> 0.
    always_comb begin
        winner    = ptr_q;
        win_found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.req[SEL_W'(ptr_q + SEL_W'(k))]) begin
                winner    = SEL_W'(ptr_q + SEL_W'(k));
                win_found = 1'b1;
            end
        end
    end

    // hold_q counts completed GRANT cycles, so hold_now is 1 in the first one.
    assign hold_now   = HOLD_W'(hold_q + HOLD_W'(1));
    assign limit_hit  = (hold_now == HOLD_W'(MAX_HOLD));
    assign req_held   = bus.req[sel_q];
    assign exit_grant = bus.done || !req_held || limit_hit;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            en_q      <= 1'b0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, GAP: state_d = win_found ? GRANT : IDLE;
            GRANT:     if (exit_grant) state_d = GAP;
            default:   state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the pointer/hold datapath.
    always_comb begin
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                if (win_found) sel_d = winner;
            end
            GRANT: begin
                if (exit_grant) begin
                    ptr_d     = SEL_W'(sel_q + SEL_W'(1));
                    // Only a pure hold-limit revocation is reported.
                    timeout_d = limit_hit && !bus.done && req_held;
                end else begin
                    hold_d = hold_now;
                end
            end
            default: ;
        endcase
        en_d  = (state_d == GRANT);
        gnt_d = en_d ? (N_REQ'(8'h80) >> sel_d) : '0;
    end

    assign bus.sel     = sel_q;
    assign bus.en      = en_q;
    assign bus.gnt     = gnt_q;
    assign bus.timeout = timeout_q;

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) en_q |-> $onehot(gnt_q));
    a_gnt_idle   : assert property (@(posedge clk) disable iff (rst) !en_q |-> (gnt_q == '0));

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scoreboard bench for rr_grant_scheduler: directed scenarios followed by randomized traffic,
// checked every cycle against a grant-level reference model.
module tb_rr_grant_scheduler;

    localparam int MAX_HOLD = 8;
    localparam int PH_IDLE  = 0;
    localparam int PH_GRANT = 1;
    localparam int PH_GAP   = 2;

    logic clk;
    logic rst;

    rr_grant_scheduler_if bus();

    rr_grant_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0] sel;
        logic       en;
        logic [7:0] gnt;
        logic       timeout;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: which phase we are in, who holds the grant, how long it has held.
    int   m_phase;
    int   m_ptr;
    int   m_sel;
    int   m_age;
    bit   m_to;

    task automatic model_step(input logic r_rst, input logic [7:0] r, input logic d);
        bit at_limit;
        bit found;
        int idx;
        m_to = 1'b0;
        if (r_rst) begin
            m_phase = PH_IDLE;
            m_ptr   = 0;
            m_sel   = 0;
            m_age   = 0;
        end else if (m_phase == PH_GRANT) begin
            at_limit = (m_age == MAX_HOLD);
            if (d || !r[m_sel] || at_limit) begin
                m_to    = at_limit && !d && r[m_sel];
                m_ptr   = (m_sel + 1) % 8;
                m_phase = PH_GAP;
                m_age   = 0;
            end else begin
                m_age++;
            end
        end else begin
            if (r != 8'h00) begin
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    idx = (m_ptr + k) % 8;
                    if (!found && r[idx]) begin
                        m_sel = idx;
                        found = 1'b1;
                    end
                end
                m_phase = PH_GRANT;
                m_age   = 1;
            end else begin
                m_phase = PH_IDLE;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic cyc(input logic r_rst, input logic [7:0] r_req, input logic r_done, input string tag);
        exp_t e;
        @(negedge clk);
        rst      = r_rst;
        bus.req  = r_req;
        bus.done = r_done;
        model_step(r_rst, r_req, r_done);
        e.sel     = 3'(m_sel);
        e.en      = (m_phase == PH_GRANT);
        e.gnt     = e.en ? 8'(32'h80 >> m_sel) : 8'h00;
        e.timeout = m_to;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    // Monitor: compare presented outputs against the oldest queued expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_tests++;
                if (bus.en !== e.en || bus.sel !== e.sel || bus.gnt !== e.gnt || bus.timeout !== e.timeout) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got sel=%0d en=%b gnt=%b timeout=%b, expected sel=%0d en=%b gnt=%b timeout=%b",
                             e.tag, $time, bus.sel, bus.en, bus.gnt, bus.timeout,
                             e.sel, e.en, e.gnt, e.timeout);
                end
            end
        end
    end

    initial begin : driver
        logic [7:0] rq;
        logic       rr;
        logic       dn;
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        m_phase  = PH_IDLE;
        m_ptr    = 0;
        m_sel    = 0;
        m_age    = 0;
        m_to     = 1'b0;

        cyc(1'b1, 8'h00, 1'b0, "reset");
        cyc(1'b1, 8'h00, 1'b0, "reset");
        cyc(1'b0, 8'h00, 1'b1, "idle_ignores_done");

        // Single request right after reset.
        cyc(1'b0, 8'h04, 1'b0, "single_req");
        repeat (4) cyc(1'b0, 8'h04, 1'b1, "single_req");

        // Full rotation with done every grant cycle.
        cyc(1'b1, 8'h00, 1'b0, "reset");
        repeat (20) cyc(1'b0, 8'hFF, 1'b1, "rotation");

        // Hold limit with a sole persistent requester.
        cyc(1'b1, 8'h00, 1'b0, "reset");
        repeat (22) cyc(1'b0, 8'h08, 1'b0, "hold_limit");

        // done arriving in the same cycle as the hold limit.
        cyc(1'b1, 8'h00, 1'b0, "reset");
        for (int i = 0; i < 22; i++)
            cyc(1'b0, 8'h08, (m_phase == PH_GRANT && m_age == MAX_HOLD), "limit_and_done");

        // Request withdrawn in the third grant cycle.
        cyc(1'b1, 8'h00, 1'b0, "reset");
        for (int i = 0; i < 12; i++)
            cyc(1'b0, (m_phase == PH_GRANT && m_age == 3) ? 8'h00 : 8'h08, 1'b0, "withdraw");

        // Reset while requester 5 holds the grant, then full contention.
        cyc(1'b1, 8'h00, 1'b0, "reset");
        repeat (3) cyc(1'b0, 8'h20, 1'b0, "pre_reset_grant");
        cyc(1'b1, 8'h20, 1'b0, "reset_mid_grant");
        repeat (6) cyc(1'b0, 8'hFF, 1'b1, "after_reset");

        // Reset landing in GAP.
        repeat (2) cyc(1'b0, 8'h40, 1'b1, "pre_gap_reset");
        cyc(1'b1, 8'h40, 1'b0, "reset_in_gap");
        repeat (4) cyc(1'b0, 8'hC1, 1'b0, "after_gap_reset");

        // Randomized traffic with sticky request patterns.
        rq = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                rq = 8'($urandom);
                if ($urandom_range(0, 2) == 0) rq = rq & 8'($urandom);
            end
            dn = ($urandom_range(0, 9) == 0);
            rr = ($urandom_range(0, 199) == 0);
            cyc(rr, rq, dn, "random");
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 Parameter MAX_HOLD, default 8, is the maximum number of consecutive cycles one grant may last; the legal range SHALL be 1..15.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request vector; bit k is requester k.
REQ-005 done  input  1  the current grant holder has finished; sampled only in GRANT.
REQ-006 sel  output  3  encoded index of the granted requester, driving the 3-to-8 decoder select.
REQ-007 en  output  1  grant valid, driving the decoder enable.
REQ-008 gnt  output  8  one-hot grant; requester k SHALL map to gnt bit (7-k), so sel=0 gives 8'b1000_0000.
REQ-009 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.
REQ-010 All outputs SHALL be registered, with no combinational path from req or done to any output.

Function
REQ-011 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-012 IDLE:
- en=0, gnt=0.
- If req is nonzero, latch the winner into sel and go to GRANT.
- Otherwise stay in IDLE.
REQ-013 Winner selection: the first set bit of req, searching upward from the priority pointer ptr and wrapping from 7 to 0.
REQ-014 Latency: a request sampled in IDLE at edge N SHALL produce en=1 and a valid gnt after edge N.
REQ-015 GRANT:
- en=1 and gnt=one-hot(sel).
- sel is stable for the whole grant.
- The 4-bit hold counter is 1 in the first GRANT cycle and increments each cycle.
REQ-016 GRANT exit conditions, any of which moves the FSM to GAP on the next edge:
- (a) done=1;
- (b) req[sel]=0;
- (c) the hold counter equals MAX_HOLD.
REQ-017 On exit from GRANT, ptr SHALL become (sel+1) mod 8, wrapping from 7 to 0.
REQ-018 timeout SHALL be 1 during the first GAP cycle only when exit was caused solely by (c).
- If done=1 or req[sel]=0 in the same cycle as the limit, timeout SHALL stay 0.
REQ-019 GAP:
- Lasts exactly one cycle with en=0 and gnt=0.
- Arbitrates as in IDLE: go to GRANT if req is nonzero, otherwise to IDLE.
REQ-020 Two consecutive grants SHALL always be separated by exactly one en=0 cycle when requests are pending.
REQ-021 sel SHALL hold the last granted index whenever en=0.
REQ-022 gnt SHALL be 8'b0 whenever en=0, and SHALL have exactly one bit set whenever en=1.
REQ-023 A sole persistent requester SHALL be re-granted after each GAP.
REQ-024 Requesters SHALL NOT starve: any requester holding req high SHALL be granted within 8 grant periods.
REQ-025 done SHALL be ignored in IDLE and GAP.
REQ-026 The hold counter SHALL clear to 0 on entry to GRANT.

Reset
REQ-027 On rst=1 at an edge, the block SHALL load:
- state=IDLE, ptr=0, sel=0, en=0, gnt=8'b0, timeout=0, hold counter=0.
REQ-028 rst SHALL take priority over every other event, including reset asserted mid-GRANT or in GAP.
- The grant SHALL drop at that edge with no timeout pulse.
REQ-029 After rst is released, the first arbitration SHALL search from index 0.

Verification
REQ-030 Single request: after reset, req=8'b0000_0100 -> next cycle en=1, sel=2, gnt=8'b0010_0000.
REQ-031 Full rotation: req=8'hFF with done=1 in every GRANT cycle -> sel sequence 0,1,...,7,0, with one en=0 cycle between grants.
REQ-032 Hold limit: req=8'b0000_1000 held, done=0, MAX_HOLD=8 -> en=1 for exactly 8 cycles, then timeout=1 for one cycle with en=0, then sel=3 is re-granted.
REQ-033 Simultaneous limit and done: done=1 in the 8th GRANT cycle -> GAP entered, timeout=0.
REQ-034 Request withdrawal: req[sel] drops in GRANT cycle 3 -> en=0 on the next cycle, timeout=0, ptr=sel+1.
REQ-035 Reset mid-grant: rst=1 while sel=5 is granted -> next cycle en=0, gnt=0, sel=0; then req=8'hFF grants sel=0 first.
